// File: rtl/d_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// d_sram_like_bridge
//
// Converts the pipeline's single-cycle data-SRAM request (M stage) into a
// split address/data "sram-like" bus transaction. The block stalls the
// pipeline while the access is outstanding. The returned read word is buffered
// until the rest of the pipeline releases M, so that no access is issued twice.
//
// Parameters:
//   READ_ALIGN      1: reads are driven word-aligned (addr[1:0] = 0), size 2
//                   0: the read address is passed through unmodified
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   data_sram_*     CPU side: en, byte write enables, address, write data;
//                   data_sram_rdata is the buffered read word for the W stage
//   i_stall         stall requested by every other pipeline source
//   d_stall         stall request from this block
//   data_req/wr/size/addr/wdata
//                   bus request channel
//   data_addr_ok    bus accepted the request this cycle
//   data_data_ok    bus read data valid / write complete this cycle
//   data_rdata      bus read data
// -----------------------------------------------------------------------------
module d_sram_like_bridge #(
    parameter int unsigned READ_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,

    input  logic        i_stall,
    output logic        d_stall,

    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        HOLD
    } state_t;

    state_t      state_q;
    logic [31:0] rdata_q;

    logic        is_read;

    assign is_read = (data_sram_wen == 4'b0000);

    // ------------------------------------------------------------------
    // Request channel: taken combinationally from the CPU inputs, which
    // the pipeline keeps stable while d_stall is asserted.
    // ------------------------------------------------------------------
    assign data_req   = (state_q == IDLE) & data_sram_en;
    assign data_wr    = ~is_read;
    assign data_wdata = data_sram_wdata;

    always_comb begin
        data_size = 2'd2;
        unique case (data_sram_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: data_size = 2'd0;
            4'b0011, 4'b1100:                   data_size = 2'd1;
            // Word stores, reads, and illegal enable patterns all use size 2.
            default:                            data_size = 2'd2;
        endcase
    end

    always_comb begin
        data_addr = data_sram_addr;
        if (is_read && (READ_ALIGN != 0)) begin
            data_addr = {data_sram_addr[31:2], 2'b00};
        end
    end

    // Stall stays high through the completion cycle and drops only in HOLD.
    assign d_stall         = data_sram_en & (state_q != HOLD);
    assign data_sram_rdata = rdata_q;

    // ------------------------------------------------------------------
    // Access FSM with the registered read-word buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // data_ok without an accepted address is ignored here.
                    if (data_sram_en && data_addr_ok) begin
                        if (data_data_ok) begin
                            state_q <= HOLD;
                            if (is_read) begin
                                rdata_q <= data_rdata;
                            end
                        end else begin
                            state_q <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (data_data_ok) begin
                        state_q <= HOLD;
                        if (is_read) begin
                            rdata_q <= data_rdata;
                        end
                    end
                end
                HOLD: begin
                    // The pipeline advances past M on the edge where
                    // i_stall is low; only then may a new access start.
                    if (!i_stall) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// tb_d_sram_like_bridge
//
// Table-driven checks of the request fields, directed multi-cycle sequences,
// then randomized traffic against a transaction-level reference model.
// Two instances share all inputs: READ_ALIGN = 1 (main) and READ_ALIGN = 0.
// -----------------------------------------------------------------------------
module tb_d_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sram_rdata;
    logic        i_stall;
    logic        d_stall;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] brdata;

    logic [31:0] u1_sram_rdata;
    logic        u1_d_stall;
    logic        u1_req;
    logic        u1_wr;
    logic [1:0]  u1_size;
    logic [31:0] u1_baddr;
    logic [31:0] u1_bwdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    d_sram_like_bridge #(.READ_ALIGN(1)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (sram_rdata),
        .i_stall         (i_stall),
        .d_stall         (d_stall),
        .data_req        (req),
        .data_wr         (wr),
        .data_size       (size),
        .data_addr       (baddr),
        .data_wdata      (bwdata),
        .data_addr_ok    (addr_ok),
        .data_data_ok    (data_ok),
        .data_rdata      (brdata)
    );

    d_sram_like_bridge #(.READ_ALIGN(0)) u_dut_na (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (u1_sram_rdata),
        .i_stall         (i_stall),
        .d_stall         (u1_d_stall),
        .data_req        (u1_req),
        .data_wr         (u1_wr),
        .data_size       (u1_size),
        .data_addr       (u1_baddr),
        .data_wdata      (u1_bwdata),
        .data_addr_ok    (addr_ok),
        .data_data_ok    (data_ok),
        .data_rdata      (brdata)
    );

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr_a1;
        logic [31:0] exp_addr_a0;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en      = 1'b0;
        wen     = 4'b0000;
        addr    = '0;
        wdata   = '0;
        i_stall = 1'b0;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        brdata  = '0;
    endtask

    // Expected bus size from the byte-enable pattern.
    function automatic logic [1:0] size_of(input logic [3:0] w);
        case (w)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
            4'b0011, 4'b1100:                   return 2'd1;
            default:                            return 2'd2;
        endcase
    endfunction

    logic [3:0]  wlist [9];
    logic        m_acc;    // address accepted, data not yet returned
    logic        m_done;   // access finished, waiting for pipeline release
    logic        m_adv;    // pipeline advanced on the last edge
    logic [31:0] m_buf;
    logic        e_req;
    logic        e_stall;

    initial begin
        vecs[0]  = '{4'b0000, 32'h8000_0006, 1'b0, 2'd2, 32'h8000_0004, 32'h8000_0006};
        vecs[1]  = '{4'b0000, 32'h0000_0003, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0003};
        vecs[2]  = '{4'b0001, 32'h0000_1003, 1'b1, 2'd0, 32'h0000_1003, 32'h0000_1003};
        vecs[3]  = '{4'b0010, 32'h0000_2001, 1'b1, 2'd0, 32'h0000_2001, 32'h0000_2001};
        vecs[4]  = '{4'b0100, 32'h0000_1002, 1'b1, 2'd0, 32'h0000_1002, 32'h0000_1002};
        vecs[5]  = '{4'b1000, 32'h0000_3003, 1'b1, 2'd0, 32'h0000_3003, 32'h0000_3003};
        vecs[6]  = '{4'b0011, 32'h0000_4000, 1'b1, 2'd1, 32'h0000_4000, 32'h0000_4000};
        vecs[7]  = '{4'b1100, 32'h0000_4002, 1'b1, 2'd1, 32'h0000_4002, 32'h0000_4002};
        vecs[8]  = '{4'b1111, 32'h0000_5004, 1'b1, 2'd2, 32'h0000_5004, 32'h0000_5004};
        vecs[9]  = '{4'b0101, 32'h0000_6001, 1'b1, 2'd2, 32'h0000_6001, 32'h0000_6001};
        vecs[10] = '{4'b1110, 32'h0000_7001, 1'b1, 2'd2, 32'h0000_7001, 32'h0000_7001};

        wlist = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                  4'b0011, 4'b1100, 4'b1111};

        // ---------------- reset ----------------
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("reset_rdata", sram_rdata, 32'h0);
        chk("reset_req", {31'b0, req}, 32'h0);
        chk("reset_stall", {31'b0, d_stall}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- request field table (IDLE, addr_ok low) ----------------
        for (int i = 0; i < 11; i++) begin
            en    = 1'b1;
            wen   = vecs[i].wen;
            addr  = vecs[i].addr;
            wdata = 32'hA5A5_0000 + i;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), {31'b0, req}, 32'h1);
            chk($sformatf("vec%0d_wr", i), {31'b0, wr}, {31'b0, vecs[i].exp_wr});
            chk($sformatf("vec%0d_size", i), {30'b0, size}, {30'b0, vecs[i].exp_size});
            chk($sformatf("vec%0d_addr_a1", i), baddr, vecs[i].exp_addr_a1);
            chk($sformatf("vec%0d_addr_a0", i), u1_baddr, vecs[i].exp_addr_a0);
            chk($sformatf("vec%0d_wdata", i), bwdata, 32'hA5A5_0000 + i);
            tick();
        end
        idle_inputs();
        @(negedge clk);
        chk("en0_req", {31'b0, req}, 32'h0);
        chk("en0_stall", {31'b0, d_stall}, 32'h0);
        tick();

        // ---------------- read, data_ok three cycles after addr_ok ----------------
        en = 1'b1; wen = 4'b0000; addr = 32'h8000_0006; addr_ok = 1'b1;
        @(negedge clk);
        chk("rd_c0_req", {31'b0, req}, 32'h1);
        chk("rd_c0_addr", baddr, 32'h8000_0004);
        chk("rd_c0_size", {30'b0, size}, 32'h2);
        chk("rd_c0_wr", {31'b0, wr}, 32'h0);
        chk("rd_c0_stall", {31'b0, d_stall}, 32'h1);
        tick();
        addr_ok = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                data_ok = 1'b1;
                brdata  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            chk($sformatf("rd_c%0d_req", c), {31'b0, req}, 32'h0);
            chk($sformatf("rd_c%0d_stall", c), {31'b0, d_stall}, 32'h1);
            tick();
        end
        data_ok = 1'b0; brdata = 32'h0;
        @(negedge clk);
        chk("rd_c4_stall", {31'b0, d_stall}, 32'h0);
        chk("rd_c4_rdata", sram_rdata, 32'hDEAD_BEEF);
        chk("rd_c4_req", {31'b0, req}, 32'h0);
        tick();
        @(negedge clk);
        chk("rd_c5_idle_req", {31'b0, req}, 32'h1);
        chk("rd_c5_rdata", sram_rdata, 32'hDEAD_BEEF);
        en = 1'b0;
        tick();

        // ---------------- store byte, single-cycle completion ----------------
        en = 1'b1; wen = 4'b0100; addr = 32'h0000_1002; wdata = 32'h5A5A_5A5A;
        addr_ok = 1'b1; data_ok = 1'b1; brdata = 32'h1111_2222;
        @(negedge clk);
        chk("sb_wr", {31'b0, wr}, 32'h1);
        chk("sb_size", {30'b0, size}, 32'h0);
        chk("sb_addr", baddr, 32'h0000_1002);
        chk("sb_wdata", bwdata, 32'h5A5A_5A5A);
        chk("sb_stall", {31'b0, d_stall}, 32'h1);
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        @(negedge clk);
        chk("sb_hold_stall", {31'b0, d_stall}, 32'h0);
        chk("sb_rdata_kept", sram_rdata, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        tick();

        // ---------------- read completes under i_stall ----------------
        en = 1'b1; wen = 4'b0000; addr = 32'h0000_0040;
        addr_ok = 1'b1; data_ok = 1'b1; brdata = 32'h1234_5678; i_stall = 1'b1;
        tick();
        brdata = 32'hBAD0_BAD0;   // bus keeps signalling; none of it may be taken
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("ist%0d_req", c), {31'b0, req}, 32'h0);
            chk($sformatf("ist%0d_stall", c), {31'b0, d_stall}, 32'h0);
            chk($sformatf("ist%0d_rdata", c), sram_rdata, 32'h1234_5678);
            tick();
        end
        i_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
        @(negedge clk);
        chk("ist_rel_req", {31'b0, req}, 32'h0);
        tick();
        @(negedge clk);
        chk("ist_idle_req", {31'b0, req}, 32'h1);
        en = 1'b0;
        tick();

        // ---------------- addr_ok held low for 5 cycles ----------------
        en = 1'b1; wen = 4'b1111; addr = 32'h0000_2000; wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("aok%0d_req", c), {31'b0, req}, 32'h1);
            chk($sformatf("aok%0d_stall", c), {31'b0, d_stall}, 32'h1);
            tick();
        end
        addr_ok = 1'b1; data_ok = 1'b1;
        @(negedge clk);
        chk("aok_acc_req", {31'b0, req}, 32'h1);
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        @(negedge clk);
        chk("aok_hold_stall", {31'b0, d_stall}, 32'h0);
        chk("aok_rdata", sram_rdata, 32'h1234_5678);
        tick();
        idle_inputs();
        tick();

        // ---------------- reset while in WAIT_DATA ----------------
        en = 1'b1; wen = 4'b0000; addr = 32'h0000_0100; addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        @(negedge clk);
        chk("wd_stall", {31'b0, d_stall}, 32'h1);
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstwd_rdata", sram_rdata, 32'h0);
        chk("rstwd_req", {31'b0, req}, 32'h0);
        chk("rstwd_stall", {31'b0, d_stall}, 32'h0);
        en = 1'b1;
        #1;
        chk("rstwd_idle_req", {31'b0, req}, 32'h1);
        en = 1'b0;
        tick();

        // ---------------- randomized traffic vs reference model ----------------
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_acc = 1'b0; m_done = 1'b0; m_adv = 1'b0; m_buf = '0;
        for (int c = 0; c < 3000; c++) begin
            // A new request may be presented only when M is free.
            if (!m_acc && !m_done && (!en || m_adv)) begin
                en    = ($urandom_range(0, 3) != 0);
                wen   = wlist[$urandom_range(0, 8)];
                addr  = $urandom;
                wdata = $urandom;
            end
            addr_ok = ($urandom_range(0, 2) == 0);
            data_ok = ($urandom_range(0, 2) == 0);
            brdata  = $urandom;
            i_stall = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            e_req   = en && !m_acc && !m_done;
            e_stall = en && !m_done;
            chk("rnd_req", {31'b0, req}, {31'b0, e_req});
            chk("rnd_stall", {31'b0, d_stall}, {31'b0, e_stall});
            chk("rnd_rdata", sram_rdata, m_buf);
            if (e_req) begin
                chk("rnd_wr", {31'b0, wr}, {31'b0, (wen != 4'b0000)});
                chk("rnd_size", {30'b0, size}, {30'b0, size_of(wen)});
                chk("rnd_addr", baddr, (wen == 4'b0000) ? (addr & ~32'h3) : addr);
                chk("rnd_addr_na", u1_baddr, addr);
                chk("rnd_wdata", bwdata, wdata);
            end
            m_adv = 1'b0;
            if (m_done) begin
                if (!i_stall) begin
                    m_done = 1'b0;
                    m_adv  = 1'b1;
                end
            end else if (m_acc) begin
                if (data_ok) begin
                    m_acc  = 1'b0;
                    m_done = 1'b1;
                    if (wen == 4'b0000) m_buf = brdata;
                end
            end else if (en && addr_ok) begin
                if (data_ok) begin
                    m_done = 1'b1;
                    if (wen == 4'b0000) m_buf = brdata;
                end else begin
                    m_acc = 1'b1;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
